// File: rtl/exec_unit.sv
// Multi-cycle execute/writeback stage: IDLE -> READ -> EXEC -> WB, with an
// iterative shift-add multiplier and registered zero/carry status flags.
module exec_unit #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        opcode,
  input  logic [ADDR_W-1:0] rd,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [7:0]        imm,
  output logic [ADDR_W-1:0] read_address1,
  output logic [ADDR_W-1:0] read_address2,
  input  logic [DATA_W-1:0] read_data1,
  input  logic [DATA_W-1:0] read_data2,
  output logic              write_en,
  output logic [ADDR_W-1:0] write_address,
  output logic [DATA_W-1:0] write_data,
  output logic              done,
  output logic              flag_z,
  output logic              flag_c
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_LDI = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_CMP = 4'd9;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t              state_reg;
  logic [3:0]          op_reg;
  logic [7:0]          imm_reg;
  logic [DATA_W-1:0]   a_reg;
  logic [DATA_W-1:0]   b_reg;
  logic [2*DATA_W-1:0] acc_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic                res_c_reg;

  logic [DATA_W-1:0]   alu_res;
  logic                alu_c;
  logic [DATA_W:0]     wide;
  logic [CNT_W-1:0]    shamt;
  logic [2*DATA_W-1:0] acc_next;
  logic                op_writes;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    wide    = '0;
    shamt   = b_reg[CNT_W-1:0];
    case (op_reg)
      OP_ADD: begin
        wide    = {1'b0, a_reg} + {1'b0, b_reg};
        alu_res = wide[DATA_W-1:0];
        alu_c   = wide[DATA_W];
      end
      OP_SUB, OP_CMP: begin
        wide    = {1'b0, a_reg} - {1'b0, b_reg};
        alu_res = wide[DATA_W-1:0];
        alu_c   = wide[DATA_W];
      end
      OP_AND: alu_res = a_reg & b_reg;
      OP_OR:  alu_res = a_reg | b_reg;
      OP_XOR: alu_res = a_reg ^ b_reg;
      // Extra bit above (SHL) or below (SHR) catches the last bit shifted out.
      OP_SHL: begin
        wide    = {1'b0, a_reg} << shamt;
        alu_res = wide[DATA_W-1:0];
        alu_c   = wide[DATA_W];
      end
      OP_SHR: begin
        wide    = {a_reg, 1'b0} >> shamt;
        alu_res = wide[DATA_W:1];
        alu_c   = wide[0];
      end
      OP_LDI: alu_res = DATA_W'(imm_reg);
      default: ;
    endcase
  end

  assign acc_next  = acc_reg + (b_reg[cnt_reg] ? ({{DATA_W{1'b0}}, a_reg} << cnt_reg) : '0);
  assign op_writes = (op_reg <= OP_MUL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      instr_ready   <= 1'b0;
      op_reg        <= '0;
      imm_reg       <= '0;
      read_address1 <= '0;
      read_address2 <= '0;
      write_address <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      res_c_reg     <= 1'b0;
      write_data    <= '0;
      write_en      <= 1'b0;
      done          <= 1'b0;
      flag_z        <= 1'b0;
      flag_c        <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (instr_valid && instr_ready) begin
            op_reg        <= opcode;
            imm_reg       <= imm;
            write_address <= rd;
            read_address1 <= rs1;
            read_address2 <= rs2;
            instr_ready   <= 1'b0;
            state_reg     <= READ;
          end else begin
            instr_ready <= 1'b1;
          end
        end
        READ: begin
          a_reg     <= read_data1;
          b_reg     <= read_data2;
          acc_reg   <= '0;
          cnt_reg   <= '0;
          state_reg <= EXEC;
        end
        EXEC: begin
          if (op_reg == OP_MUL) begin
            acc_reg <= acc_next;
            cnt_reg <= cnt_reg + CNT_W'(1);
            if (cnt_reg == CNT_LAST) begin
              write_data <= acc_next[DATA_W-1:0];
              res_c_reg  <= |acc_next[2*DATA_W-1:DATA_W];
              write_en   <= 1'b1;
              done       <= 1'b1;
              state_reg  <= WB;
            end
          end else begin
            write_data <= alu_res;
            res_c_reg  <= alu_c;
            write_en   <= op_writes;
            done       <= 1'b1;
            state_reg  <= WB;
          end
        end
        WB: begin
          write_en    <= 1'b0;
          done        <= 1'b0;
          instr_ready <= 1'b1;
          state_reg   <= IDLE;
          if (op_reg <= OP_CMP) begin
            flag_z <= (write_data == '0);
            if (op_reg != OP_LDI) flag_c <= res_c_reg;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: a behavioural register file plus an
// arithmetic reference model of results, flags and latency.
module tb_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [3:0]  opcode = '0;
  logic [3:0]  rd = '0;
  logic [3:0]  rs1 = '0;
  logic [3:0]  rs2 = '0;
  logic [7:0]  imm = '0;
  logic [3:0]  read_address1, read_address2;
  logic [15:0] read_data1, read_data2;
  logic        write_en;
  logic [3:0]  write_address;
  logic [15:0] write_data;
  logic        done, flag_z, flag_c;

  logic [15:0] rf [16];
  logic [15:0] mrf [16];
  logic        mz = 1'b0;
  logic        mc = 1'b0;
  logic        pre_we = 1'b0;
  logic [3:0]  pre_addr = '0;
  logic [15:0] pre_data = '0;
  int          vectors = 0;
  int          miscompares = 0;

  exec_unit #(.DATA_W(16), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .read_address1(read_address1), .read_address2(read_address2),
    .read_data1(read_data1), .read_data2(read_data2),
    .write_en(write_en), .write_address(write_address), .write_data(write_data),
    .done(done), .flag_z(flag_z), .flag_c(flag_c)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (write_en) rf[write_address] <= write_data;
    else if (pre_we) rf[pre_addr] <= pre_data;
  end

  assign read_data1 = rf[read_address1];
  assign read_data2 = rf[read_address2];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic preload(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
    mrf[a] = d;
  endtask

  // Reference model: plain arithmetic on the expected register contents.
  task automatic model(input logic [3:0] op, input logic [3:0] r_d, input logic [3:0] r1,
                       input logic [3:0] r2, input logic [7:0] im,
                       output logic we, output logic [15:0] res, output int lat);
    int a, b, s, t;
    longint p;
    a = int'(mrf[r1]); b = int'(mrf[r2]); s = b % 16;
    res = '0; lat = 3; t = 0;
    case (op)
      4'd0: begin t = a + b; res = 16'(t % 65536); mc = (t > 65535); end
      4'd1, 4'd9: begin t = a - b; if (t < 0) t = t + 65536; res = 16'(t); mc = (a < b); end
      4'd2: begin res = mrf[r1] & mrf[r2]; mc = 1'b0; end
      4'd3: begin res = mrf[r1] | mrf[r2]; mc = 1'b0; end
      4'd4: begin res = mrf[r1] ^ mrf[r2]; mc = 1'b0; end
      4'd5: begin t = a * (1 << s); res = 16'(t % 65536); mc = (s != 0) ? (((t / 65536) % 2) == 1) : 1'b0; end
      4'd6: begin res = 16'(a / (1 << s)); mc = (s != 0) ? (((a >> (s - 1)) % 2) == 1) : 1'b0; end
      4'd7: res = {8'h00, im};
      4'd8: begin p = longint'(a) * longint'(b); res = 16'(p % 65536); mc = (p >= 65536); lat = 18; end
      default: ;
    endcase
    if (op <= 4'd9) mz = (res == 16'd0);
    we = (op <= 4'd8);
    if (we) mrf[r_d] = res;
  endtask

  // Issues one instruction and gathers what the DUT did into a packed record:
  // {wait cycles, done latency, write count, write addr, write data,
  //  ready-high-while-busy count, done/write after WB, Z, C}.
  task automatic xact(input logic [3:0] op, input logic [3:0] r_d, input logic [3:0] r1,
                      input logic [3:0] r2, input logic [7:0] im, input bit hold,
                      output logic [50:0] got, output logic [50:0] exp);
    logic we;
    logic [15:0] res, wd;
    logic [3:0] wa;
    int lat, w, k, wen, rbad;
    bit seen;
    logic dafter;
    model(op, r_d, r1, r2, im, we, res, lat);
    exp = {8'd1, 8'(lat), we ? 4'd1 : 4'd0, we ? r_d : 4'd0, we ? res : 16'd0, 8'd0, 1'b0, mz, mc};
    opcode = op; rd = r_d; rs1 = r1; rs2 = r2; imm = im; instr_valid = 1'b1;
    w = 0;
    do begin @(negedge clk); w++; end while (!instr_ready && w < 40);
    @(posedge clk); #1;
    if (!hold) instr_valid = 1'b0;
    k = 0; seen = 0; wen = 0; rbad = 0; wa = '0; wd = '0;
    while (!seen && k < 40) begin
      @(negedge clk); k++;
      if (write_en) begin wen++; wa = write_address; wd = write_data; end
      if (instr_ready) rbad++;
      if (done) seen = 1;
    end
    @(posedge clk); #1;
    dafter = done | write_en;
    got = {8'(w), seen ? 8'(k) : 8'd0, 4'(wen), wa, wd, 8'(rbad), dafter, flag_z, flag_c};
    $display("xact op=%0d rd=%0d rs1=%0d rs2=%0d imm=%h -> lat=%0d writes=%0d wd=%h z=%b c=%b",
             op, r_d, r1, r2, im, seen ? k : 0, wen, wd, flag_z, flag_c);
  endtask

  task automatic test_reset();
    logic [32:0] outs;
    repeat (3) @(negedge clk);
    outs = {instr_ready, read_address1, read_address2, write_en, write_address,
            write_data, done, flag_z, flag_c};
    vectors++;
    if (outs !== 33'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (instr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %b expected 1", instr_ready);
    end
  endtask

  task automatic test_alu();
    logic [15:0] ta [6] = '{16'h7FFF, 16'hFFFF, 16'h0002, 16'hF0F0, 16'hF0F0, 16'hAAAA};
    logic [15:0] tb [6] = '{16'h0001, 16'h0001, 16'h0005, 16'hFF00, 16'h0F0F, 16'hAAAA};
    logic [3:0]  to [6] = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    logic [50:0] got, exp;
    for (int i = 0; i < 6; i++) begin
      preload(4'd1, ta[i]);
      preload(4'd2, tb[i]);
      xact(to[i], 4'd3, 4'd1, 4'd2, 8'h00, 1'b0, got, exp);
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL alu_%0d: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_mul();
    logic [15:0] ta [3] = '{16'h0123, 16'h00FF, 16'hFFFF};
    logic [15:0] tb [3] = '{16'h0100, 16'h0002, 16'hFFFF};
    logic [50:0] got, exp;
    for (int i = 0; i < 3; i++) begin
      preload(4'd4, ta[i]);
      preload(4'd5, tb[i]);
      xact(4'd8, 4'd9, 4'd4, 4'd5, 8'h00, 1'b0, got, exp);
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL mul_%0d: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [50:0] got, exp;
    xact(4'd7, 4'd6, 4'd0, 4'd0, 8'hA5, 1'b1, got, exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL b2b_ldi: got %h expected %h", got, exp);
    end
    xact(4'd0, 4'd7, 4'd6, 4'd6, 8'h00, 1'b1, got, exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL b2b_add_raw: got %h expected %h", got, exp);
    end
    xact(4'd9, 4'd7, 4'd6, 4'd6, 8'h00, 1'b0, got, exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL b2b_cmp: got %h expected %h", got, exp);
    end
    vectors++;
    if (rf[7] !== 16'h014A) begin
      miscompares++;
      $display("FAIL b2b_r7: got %h expected 014a", rf[7]);
    end
  endtask

  task automatic test_shift_nop();
    logic [15:0] ta [5] = '{16'h8001, 16'h0001, 16'hB3C5, 16'hB3C5, 16'h1234};
    logic [15:0] tb [5] = '{16'h0001, 16'h0001, 16'h0000, 16'h0027, 16'h0003};
    logic [3:0]  to [5] = '{4'd5, 4'd6, 4'd5, 4'd6, 4'd12};
    logic [50:0] got, exp;
    for (int i = 0; i < 5; i++) begin
      preload(4'd1, ta[i]);
      preload(4'd2, tb[i]);
      xact(to[i], 4'd10, 4'd1, 4'd2, 8'h00, 1'b0, got, exp);
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL shift_nop_%0d: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_random();
    logic [50:0] got, exp;
    bit hold;
    for (int r = 0; r < 16; r++) preload(4'(r), 16'($urandom));
    for (int i = 0; i < 40; i++) begin
      hold = (i != 39) && ($urandom_range(0, 1) == 1);
      xact(4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom), 4'($urandom),
           8'($urandom), hold, got, exp);
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL random_%0d: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [50:0] got, exp;
    logic [32:0] outs;
    logic [19:0] post;
    logic        wseen;
    preload(4'd1, 16'hFFFF);
    preload(4'd2, 16'h0001);
    xact(4'd0, 4'd3, 4'd1, 4'd2, 8'h00, 1'b0, got, exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL rstmid_pre_add: got %h expected %h", got, exp);
    end
    preload(4'd4, 16'h0123);
    preload(4'd5, 16'h0100);
    preload(4'd8, 16'h5A5A);
    opcode = 4'd8; rd = 4'd8; rs1 = 4'd4; rs2 = 4'd5; instr_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    outs = {instr_ready, read_address1, read_address2, write_en, write_address,
            write_data, done, flag_z, flag_c};
    vectors++;
    if (outs !== 33'd0) begin
      miscompares++;
      $display("FAIL rstmid_outputs: got %h expected 0", outs);
    end
    wseen = 1'b0;
    repeat (3) begin @(negedge clk); wseen = wseen | write_en | done; end
    rst_n = 1'b1;
    @(posedge clk); #1;
    mz = 1'b0; mc = 1'b0;
    post = {instr_ready, wseen | write_en | done, flag_z, flag_c, rf[8]};
    vectors++;
    if (post !== {1'b1, 1'b0, 1'b0, 1'b0, mrf[8]}) begin
      miscompares++;
      $display("FAIL rstmid_after: got %h expected %h", post, {1'b1, 3'b000, mrf[8]});
    end
    xact(4'd0, 4'd3, 4'd1, 4'd2, 8'h00, 1'b0, got, exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL rstmid_post_add: got %h expected %h", got, exp);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mul();
    test_back_to_back();
    test_shift_nop();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
